// File: rtl/io_intc_if.sv
// I/O register bus and interrupt handshake shared by the core and io_intc_unit.
//
// Handshake semantics:
//   io_wr    : one-cycle write strobe. io_addr/io_wdata are taken at the same edge.
//   io_rdata : combinational function of io_addr. There is no read strobe.
//   int_req  : held high while the controller offers line int_id. int_id is stable while int_req=1.
//   int_ack  : sampled only while int_req=1. That edge accepts the request.
//   int_done : sampled only after an ack (in service). It ends the service period.
// The master modport is the core/control-unit side. The slave modport is the controller.
interface io_intc_if #(
  parameter int DATA_W = 8,
  parameter int N_IRQ  = 4
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [2:0]        io_addr;
  logic              io_wr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              int_en;
  logic              int_req;
  logic [ID_W-1:0]   int_id;
  logic              int_ack;
  logic              int_done;

  modport master (
    output io_addr, io_wr, io_wdata, int_en, int_ack, int_done,
    input  io_rdata, int_req, int_id
  );

  modport slave (
    input  io_addr, io_wr, io_wdata, int_en, int_ack, int_done,
    output io_rdata, int_req, int_id
  );
endinterface

// File: rtl/io_intc_unit.sv
// io_intc_unit: register-mapped input/output ports plus a prioritised interrupt
// controller for the 8-bit CPU family.
// - Input ports are sampled once per cycle and read at addresses 0..N_IN-1.
// - Output ports are written at addresses 0..N_OUT-1.
// - The mask register is at MASK_ADDR. The pending register is at PEND_ADDR (write 1 to clear).
// - The priority is fixed. The lowest line index wins. There is no nesting while a line is in service.
// - state_dbg exposes the request FSM (0=IDLE, 1=REQ, 2=SERVICE).
// Optional build macro IO_INTC_LEVEL_EN: pending follows the synchronised level of irq_in
// instead of latching rising edges. In that mode W1C and ack-clear do nothing.
module io_intc_unit #(
  parameter int               DATA_W      = 8,
  parameter int               N_IN        = 2,
  parameter int               N_OUT       = 2,
  parameter int               N_IRQ       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [2:0]       MASK_ADDR   = 3'd6,
  parameter logic [2:0]       PEND_ADDR   = 3'd7,
  parameter logic [N_IRQ-1:0] MASK_RST    = {N_IRQ{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  input  logic [N_IRQ-1:0]        irq_in,
  io_intc_if.slave                bus,
  output logic [1:0]              state_dbg
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [N_IN*DATA_W-1:0]              in_q;
  logic [N_OUT*DATA_W-1:0]             out_q;
  logic [N_IRQ-1:0]                    mask_q;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0]   sync_q;
  logic [N_IRQ-1:0]                    irq_sync;
  logic [N_IRQ-1:0]                    pend;
  logic [N_IRQ-1:0]                    elig;
  logic                                any_elig;
  logic                                cur_elig;
  logic [ID_W-1:0]                     pick;
  logic [DATA_W-1:0]                   rdata;
  state_t                              state_q, state_n;
  logic [ID_W-1:0]                     id_q, id_n;
  logic                                ack_go;

  // Input ports sampled into one register stage every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_q <= '0;
    end else begin
      in_q <= in_port;
    end
  end

  // Output port and mask register writes. Unmapped addresses are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      mask_q <= MASK_RST;
    end else if (bus.io_wr) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (bus.io_addr == 3'(j)) out_q[j*DATA_W +: DATA_W] <= bus.io_wdata;
      end
      if (bus.io_addr == MASK_ADDR) mask_q <= bus.io_wdata[N_IRQ-1:0];
    end
  end

  // Synchroniser chain for the asynchronous irq lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
    end
  end

  assign irq_sync = sync_q[SYNC_STAGES-1];

`ifdef IO_INTC_LEVEL_EN
  // In level mode, pending is the synchronised line level itself.
  assign pend = irq_sync;
`else
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;

  assign rise = irq_sync & ~prev_q;
  assign w1c  = (bus.io_wr && (bus.io_addr == PEND_ADDR)) ? bus.io_wdata[N_IRQ-1:0] : '0;

  // Decode the one-hot clear of the line that is being acknowledged.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ack_go && (id_q == ID_W'(i))) ack_clr[i] = 1'b1;
    end
  end

  // Edge latch. A new rising edge beats a same-cycle W1C or ack-clear of that bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_sync;
      pend_q <= (pend_q & ~(w1c | ack_clr)) | rise;
    end
  end

  assign pend = pend_q;
`endif

  assign elig     = pend & mask_q & {N_IRQ{bus.int_en}};
  assign any_elig = |elig;

  // Fixed priority: scanning downward leaves the lowest eligible index in pick.
  always_comb begin
    pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) pick = ID_W'(i);
    end
  end

  // Check whether the line currently offered is still eligible.
  always_comb begin
    cur_elig = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (elig[i] && (id_q == ID_W'(i))) cur_elig = 1'b1;
    end
  end

  // FSM state and in-service id registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_n;
      id_q    <= id_n;
    end
  end

  // Next-state logic. A stray ack or done in the wrong state falls through unused.
  always_comb begin
    state_n = state_q;
    id_n    = id_q;
    ack_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_elig) begin
          state_n = ST_REQ;
          id_n    = pick;
        end
      end
      ST_REQ: begin
        if (!cur_elig) begin
          state_n = ST_IDLE;
        end else if (bus.int_ack) begin
          state_n = ST_SERVICE;
          ack_go  = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.int_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Read mux. The input ports take the low addresses. Unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    if (bus.io_addr == MASK_ADDR) begin
      rdata[N_IRQ-1:0] = mask_q;
    end else if (bus.io_addr == PEND_ADDR) begin
      rdata[N_IRQ-1:0] = pend;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (bus.io_addr == 3'(i)) rdata = in_q[i*DATA_W +: DATA_W];
    end
  end

  assign bus.io_rdata = rdata;
  assign bus.int_req  = (state_q == ST_REQ);
  assign bus.int_id   = id_q;
  assign out_port     = out_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/io_intc_unit.md
Name: io_intc_unit

Overview:
- Parametrised I/O port and interrupt controller for the 8-bit CPU family.
- Replaces the single fixed in/out port and single interrupt line with N input ports, N output ports and N prioritised interrupt lines, behind one register-mapped I/O bus.
- Sits between the core's IN/OUT datapath and the control unit's interrupt handshake.
- Pending and mask state are readable and writable by software.

Parameters:
- DATA_W, 8, I/O data width.
- N_IN, 2, number of input ports (1..4).
- N_OUT, 2, number of output ports (1..4).
- N_IRQ, 4, number of interrupt lines (1..DATA_W).
- SYNC_STAGES, 2, synchroniser depth on irq_in (>=2).
- MASK_ADDR, 3'd6, I/O address of the mask register.
- PEND_ADDR, 3'd7, I/O address of the pending register.
- MASK_RST, {N_IRQ{1'b1}}, reset value of the mask (1 = enabled).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_port  in  N_IN*DATA_W  external input ports, port i = bits [i*DATA_W +: DATA_W]
- out_port  out  N_OUT*DATA_W  registered output ports
- io_addr  in  3  I/O register address
- io_wr  in  1  write strobe, one cycle
- io_wdata  in  DATA_W  write data
- io_rdata  out  DATA_W  read data, combinational from io_addr
- irq_in  in  N_IRQ  asynchronous interrupt lines, rising-edge triggered
- int_en  in  1  global interrupt enable from the core
- int_req  out  1  interrupt request to the control unit
- int_id  out  $clog2(N_IRQ) (min 1)  index of the requested or in-service line
- int_ack  in  1  control unit accepts the request (vector fetch started)
- int_done  in  1  return-from-interrupt executed

Behaviour:
- Reset (rstn=0, async):
  - out_port=0, mask=MASK_RST, pending=0.
  - Synchronisers and edge registers=0, input sample registers=0.
  - FSM=IDLE, int_req=0, int_id=0.
- Input ports:
  - Sampled into one register stage every cycle.
  - A read at address i < N_IN returns the sample.
- Reads (io_rdata):
  - addr < N_IN: input sample.
  - MASK_ADDR: mask, zero-extended.
  - PEND_ADDR: pending, zero-extended.
  - Any other address: 0.
- Writes (io_wr=1), taking effect at the next edge:
  - addr < N_OUT: out_port[addr] <= io_wdata.
  - MASK_ADDR: mask <= io_wdata[N_IRQ-1:0].
  - PEND_ADDR: write-1-to-clear pending bits.
  - Any other address: ignored.
- Edge detection:
  - irq_in passes through SYNC_STAGES flops, then a previous-value flop.
  - pending[i] is set at the edge where sync=1 and prev=0.
  - irq high before edge k gives pending set at edge k+SYNC_STAGES.
  - Masking does not block latching; masked lines still become pending.
- Set/clear priority:
  - A set wins over a simultaneous W1C or ack-clear of the same bit.
- Request eligibility and priority:
  - eligible = pending & mask, gated by int_en.
  - Lowest index has highest priority.
- FSM states IDLE, REQ, SERVICE:
  - IDLE -> REQ when eligible != 0. int_id <= index of the highest-priority eligible line. int_req=1 from the following cycle, i.e. 1 cycle after pending.
  - REQ: int_req=1 and int_id held stable. If int_en drops or the line is masked or cleared before ack, go to IDLE and drop int_req. Otherwise wait.
  - REQ -> SERVICE on int_ack. pending[int_id] is cleared on that edge. int_req=0.
  - SERVICE: no new request (no nesting). int_id holds the in-service line. Edges keep latching into pending.
  - SERVICE -> IDLE on int_done. A new request can be raised 1 cycle later.
- Protocol errors:
  - int_ack outside REQ is ignored.
  - int_done outside SERVICE is ignored.
- Reset mid-operation: everything returns to reset values immediately, and interrupts in flight are lost.

Optional Feature:
- Macro IO_INTC_LEVEL_EN.
- Defined:
  - pending[i] = synchronised level of irq_in[i]. No edge register.
  - W1C on PEND_ADDR and ack-clear have no effect.
  - A line still high when SERVICE ends re-requests.
- Undefined: edge-triggered latching as described above.

Test Plan:
- Reset values: pulse rstn low mid-REQ -> out_port=0, int_req=0, read MASK_ADDR=8'h0F, read PEND_ADDR=8'h00.
- Port I/O:
  - Write 8'hA5 to addr 1 -> out_port[15:8]=8'hA5 the next cycle.
  - Drive in_port[7:0]=8'h3C, read addr 0 -> 8'h3C one cycle later.
  - Write to addr 5 -> no state change.
- Basic interrupt: irq_in[2] rises before edge k, int_en=1 -> pending=4'b0100 at k+2, int_req=1 and int_id=2 at k+3. int_ack -> pending=0, int_req=0. int_done -> IDLE.
- Priority and mask:
  - irq_in[3] and irq_in[1] rise together -> int_id=1.
  - After service, int_id=3.
  - With mask=4'b0111 the line-3 request is withheld. pending bit 3 stays set and is cleared by writing 8'h08 to PEND_ADDR.
- Simultaneous events:
  - New irq_in[0] edge on the int_ack edge for line 0 -> pending[0] remains 1.
  - Edge arriving during SERVICE -> int_req stays 0 until int_done, then asserts the next cycle.
- Gating: int_en=0 with pending=4'b0001 -> int_req=0. Raise int_en -> int_req=1 one cycle later. Drop int_en while in REQ -> int_req=0 and FSM returns to IDLE.
